// File: rtl/doodlejump_soc_keys_pio_pkg.sv
// Shared constants for the doodlejump_soc input PIO: Avalon word addresses, edge modes
// and the decoded bus command.
package doodlejump_soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef struct packed {
    logic       wr;
    logic [1:0] addr;
  } pio_cmd_t;

endpackage

// File: rtl/doodlejump_soc_keys_pio_if.sv
// Avalon-MM slave bus of the keys PIO (word addressed, registered readdata).
interface doodlejump_soc_keys_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/doodlejump_soc_pio_debounce.sv
// One input bit: 2-flop synchroniser, optionally followed by a stable-count debouncer
// (enabled by KEYS_PIO_DEBOUNCE_EN).
module doodlejump_soc_pio_debounce
`ifdef KEYS_PIO_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], raw_i};
  end

`ifdef KEYS_PIO_DEBOUNCE_EN
  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // Counter runs only while sync disagrees with stable; it never passes CNT_LAST.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q >= CNT_LAST) stable_d = sync_q[1];
      else                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  assign stable_o = sync_q[1];
`endif

endmodule

// File: rtl/doodlejump_soc_keys_pio.sv
// Avalon-MM input PIO for push-buttons/switches: sync (+ optional KEYS_PIO_DEBOUNCE_EN
// debounce), sticky W1C edge capture, masked level irq.
module doodlejump_soc_keys_pio
  import doodlejump_soc_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned EDGE_TYPE = EDGE_ANY
`ifdef KEYS_PIO_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_CYCLES = 50000
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  doodlejump_soc_keys_pio_if.slave    avs,
  input  logic [WIDTH-1:0]            in_port,
  output logic                        irq
);

  logic [WIDTH-1:0] stable, stable_dly_q, edge_det;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d, clr;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  pio_cmd_t         cmd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef KEYS_PIO_DEBOUNCE_EN
    doodlejump_soc_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
`else
    doodlejump_soc_pio_debounce u_db (
`endif
      .clk      (clk),
      .reset    (reset),
      .raw_i    (in_port[i]),
      .stable_o (stable[i])
    );
  end

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd;
    assign unused_wd = ^avs.writedata[31:WIDTH];
  end

  always_comb begin
    cmd.wr   = avs.chipselect & ~avs.write_n;
    cmd.addr = avs.address;
  end

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = stable & ~stable_dly_q;
      EDGE_FALL: edge_det = ~stable & stable_dly_q;
      default:   edge_det = stable ^ stable_dly_q;
    endcase
  end

  // A fresh edge wins over a W1C of the same bit in the same cycle.
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (cmd.wr && cmd.addr == PIO_ADDR_IRQMASK) irq_mask_d = avs.writedata[WIDTH-1:0];
    if (cmd.wr && cmd.addr == PIO_ADDR_EDGECAP) clr        = avs.writedata[WIDTH-1:0];
    edge_cap_d = (edge_cap_q & ~clr) | edge_det;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  always_comb begin
    rdata_d = '0;
    case (cmd.addr)
      PIO_ADDR_DATA:    rdata_d[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: rdata_d[WIDTH-1:0] = irq_mask_q;
      PIO_ADDR_EDGECAP: rdata_d[WIDTH-1:0] = edge_cap_q;
      default:          rdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_dly_q <= '0;
      irq_mask_q   <= '0;
      edge_cap_q   <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable;
      irq_mask_q   <= irq_mask_d;
      edge_cap_q   <= edge_cap_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign avs.readdata = rdata_q;
  assign irq          = irq_q;

endmodule
